// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer owning the HI/LO pair: pipelined mult/multu, iterative restoring
// div/divu, and mthi/mtlo. Stalls mfhi/mflo readers while an op is in flight.
module muldiv_ctrl #(
    parameter int unsigned MUL_LATENCY = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    input  logic        rd_req,
    output logic        stall,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {StIdle, StMul, StDiv} state_t;

    localparam logic [2:0] OpMult  = 3'd0;
    localparam logic [2:0] OpMultu = 3'd1;
    localparam logic [2:0] OpDiv   = 3'd2;
    localparam logic [2:0] OpDivu  = 3'd3;
    localparam logic [2:0] OpMthi  = 3'd4;
    localparam logic [2:0] OpMtlo  = 3'd5;

    localparam logic [4:0] MulLast = 5'(MUL_LATENCY - 1);
    localparam logic [4:0] DivLast = 5'd31;

    state_t      r_state, w_state_nxt;
    logic [4:0]  r_cnt, w_cnt_nxt;
    logic [31:0] r_a, w_a_nxt;
    logic [31:0] r_b, w_b_nxt;
    logic        r_signed, w_signed_nxt;
    logic [31:0] r_quo, w_quo_nxt;
    logic [31:0] r_rem, w_rem_nxt;
    logic [31:0] r_hi, w_hi_nxt;
    logic [31:0] r_lo, w_lo_nxt;
    logic        r_busy;

    logic        w_accept;
    logic        w_a_neg, w_b_neg;
    logic [31:0] w_dvs;
    logic [65:0] w_ma, w_mb, w_prod;
    logic [32:0] w_rem_sh, w_diff;
    logic        w_fits;
    logic [31:0] w_quo_iter, w_rem_iter;
    logic [31:0] w_quo_fix, w_rem_fix;

    assign w_accept = op_valid & (r_state == StIdle) & ~flush;

    assign w_a_neg = r_signed & r_a[31];
    assign w_b_neg = r_signed & r_b[31];

    // Product is formed from the latched operands and committed on the last MUL cycle.
    assign w_ma   = {{34{w_a_neg}}, r_a};
    assign w_mb   = {{34{w_b_neg}}, r_b};
    assign w_prod = w_ma * w_mb;

    // r_quo starts as the dividend magnitude and is shifted out MSB-first as quotient bits enter.
    assign w_dvs      = w_b_neg ? (32'd0 - r_b) : r_b;
    assign w_rem_sh   = {r_rem, r_quo[31]};
    assign w_diff     = w_rem_sh - {1'b0, w_dvs};
    assign w_fits     = ~w_diff[32];
    assign w_rem_iter = w_fits ? w_diff[31:0] : w_rem_sh[31:0];
    assign w_quo_iter = {r_quo[30:0], w_fits};
    assign w_quo_fix  = (w_a_neg ^ w_b_neg) ? (32'd0 - w_quo_iter) : w_quo_iter;
    assign w_rem_fix  = w_a_neg ? (32'd0 - w_rem_iter) : w_rem_iter;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_signed_nxt = r_signed;
        w_quo_nxt    = r_quo;
        w_rem_nxt    = r_rem;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_a_nxt      = src_a;
                    w_b_nxt      = src_b;
                    w_cnt_nxt    = 5'd0;
                    w_signed_nxt = (op == OpMult) || (op == OpDiv);
                    case (op)
                        OpMult, OpMultu: w_state_nxt = StMul;
                        OpDiv, OpDivu: begin
                            w_state_nxt = StDiv;
                            w_quo_nxt   = ((op == OpDiv) && src_a[31]) ? (32'd0 - src_a) : src_a;
                            w_rem_nxt   = 32'd0;
                        end
                        OpMthi:  w_hi_nxt = src_a;
                        OpMtlo:  w_lo_nxt = src_a;
                        default: ;
                    endcase
                end
            end
            StMul: begin
                if (flush) begin
                    w_state_nxt = StIdle;
                end else if (r_cnt == MulLast) begin
                    w_state_nxt = StIdle;
                    w_hi_nxt    = w_prod[63:32];
                    w_lo_nxt    = w_prod[31:0];
                end else begin
                    w_cnt_nxt = r_cnt + 5'd1;
                end
            end
            StDiv: begin
                if (flush) begin
                    w_state_nxt = StIdle;
                end else begin
                    w_quo_nxt = w_quo_iter;
                    w_rem_nxt = w_rem_iter;
                    w_cnt_nxt = r_cnt + 5'd1;
                    if (r_cnt == DivLast) begin
                        w_state_nxt = StIdle;
                        // Divide by zero bypasses the sign fix-up entirely.
                        if (r_b == 32'd0) begin
                            w_lo_nxt = 32'hFFFF_FFFF;
                            w_hi_nxt = r_a;
                        end else begin
                            w_lo_nxt = w_quo_fix;
                            w_hi_nxt = w_rem_fix;
                        end
                    end
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= StIdle;
            r_cnt    <= 5'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_signed <= 1'b0;
            r_quo    <= 32'd0;
            r_rem    <= 32'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_signed <= w_signed_nxt;
            r_quo    <= w_quo_nxt;
            r_rem    <= w_rem_nxt;
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
            r_busy   <= (w_state_nxt != StIdle);
        end
    end

    assign op_ready = (r_state == StIdle);
    assign busy     = r_busy;
    assign stall    = rd_req & r_busy;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule
